// File: rtl/sequence_playback.sv
// -----------------------------------------------------------------------------
// sequence_playback
//   Plays the stored Simon sequence back to the player. Entries are shown from
//   segment[0] up to and including segment[last_round]. Each 3-bit entry is
//   decoded to a one-hot LED pattern, lit for ON_CYCLES clocks and followed by
//   GAP_CYCLES dark clocks. Playback stops early at the first empty entry
//   (bit2 = 1) and never advances past index 31.
//
// Ports
//   clk         in   1            system clock, rising edge
//   reset       in   1            asynchronous, active-high reset
//   segment     in   [31:0][2:0]  sequence store; bit2 = empty, [1:0] = colour
//   start       in   1            one-cycle start request, accepted only in IDLE
//   last_round  in   5            index of final entry, sampled on accepted start
//   leds        out  4            one-hot LED drive (code n -> bit n), or zero
//   busy        out  1            high while showing or gapping
//   done        out  1            one-cycle pulse when playback ends
//   step        out  5            index of the entry shown or last shown
// -----------------------------------------------------------------------------
module sequence_playback #(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int GAP_CYCLES = 12_500_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0][2:0] segment,
  input  logic             start,
  input  logic [4:0]       last_round,
  output logic [3:0]       leds,
  output logic             busy,
  output logic             done,
  output logic [4:0]       step
);

  localparam int MAX_CYCLES = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  // The timer counts down to zero, so a phase of N cycles loads N-1.
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP,
    FINISH
  } state_t;

  state_t        r_state,  w_state_next;
  logic [TW-1:0] r_timer,  w_timer_next;
  logic [4:0]    r_lr,     w_lr_next;
  logic [1:0]    r_entry,  w_entry_next;
  logic [4:0]    r_step,   w_step_next;
  logic [3:0]    r_leds,   w_leds_next;
  logic          r_busy,   w_busy_next;
  logic          r_done,   w_done_next;
  logic [4:0]    w_next_idx;
  logic          w_last_step;

  function automatic logic [3:0] decode(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

  // At step 31 the incremented index wraps, but w_last_step is already true
  // through the step==31 term, so the wrapped lookup is never acted on.
  assign w_next_idx  = r_step + 5'd1;
  assign w_last_step = (r_step == r_lr) || (r_step == 5'd31) ||
                       segment[w_next_idx][2];

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_lr_next    = r_lr;
    w_entry_next = r_entry;
    w_step_next  = r_step;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_lr_next   = last_round;
          w_step_next = 5'd0;
          if (segment[0][2]) begin
            w_state_next = FINISH;
          end else begin
            w_entry_next = segment[0][1:0];
            w_timer_next = ON_LOAD;
            w_state_next = SHOW;
          end
        end
      end
      SHOW: begin
        if (r_timer == '0) begin
          w_timer_next = GAP_LOAD;
          w_state_next = GAP;
        end else begin
          w_timer_next = r_timer - TW'(1);
        end
      end
      GAP: begin
        if (r_timer == '0) begin
          if (w_last_step) begin
            w_state_next = FINISH;
          end else begin
            w_step_next  = w_next_idx;
            w_entry_next = segment[w_next_idx][1:0];
            w_timer_next = ON_LOAD;
            w_state_next = SHOW;
          end
        end else begin
          w_timer_next = r_timer - TW'(1);
        end
      end
      FINISH: begin
        w_timer_next = '0;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase

    // Outputs are derived from the state being entered so they can be
    // registered alongside it and appear with one cycle of latency.
    w_leds_next = (w_state_next == SHOW) ? decode(w_entry_next) : 4'b0000;
    w_busy_next = (w_state_next == SHOW) || (w_state_next == GAP);
    w_done_next = (w_state_next == FINISH);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_lr    <= 5'd0;
      r_entry <= 2'd0;
      r_step  <= 5'd0;
      r_leds  <= 4'b0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      r_lr    <= w_lr_next;
      r_entry <= w_entry_next;
      r_step  <= w_step_next;
      r_leds  <= w_leds_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  assign leds = r_leds;
  assign busy = r_busy;
  assign done = r_done;
  assign step = r_step;

endmodule

// File: tb/tb_sequence_playback.sv
// -----------------------------------------------------------------------------
// tb_sequence_playback
//   Self-checking bench for sequence_playback with ON_CYCLES=3, GAP_CYCLES=2.
//   A reference model turns a segment snapshot and last_round into the full
//   expected per-cycle trace of {leds, busy, done, step}, which is compared
//   against the DUT every cycle after start.
// -----------------------------------------------------------------------------
module tb_sequence_playback;

  localparam int ON  = 3;
  localparam int GAP = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0][2:0] segment;
  logic             start;
  logic [4:0]       last_round;
  logic [3:0]       leds;
  logic             busy;
  logic             done;
  logic [4:0]       step;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] leds;
    logic       busy;
    logic       done;
    logic [4:0] step;
  } obs_t;

  obs_t exp_q[$];

  always #5 clk = ~clk;

  sequence_playback #(
    .ON_CYCLES  (ON),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .segment    (segment),
    .start      (start),
    .last_round (last_round),
    .leds       (leds),
    .busy       (busy),
    .done       (done),
    .step       (step)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input obs_t exp);
    obs_t obs;
    obs = {leds, busy, done, step};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed leds=%b busy=%b done=%b step=%0d, expected leds=%b busy=%b done=%b step=%0d",
             tag, obs.leds, obs.busy, obs.done, obs.step,
             exp.leds, exp.busy, exp.done, exp.step);
    end
  endtask

  // Reference model: each played entry contributes ON lit cycles and GAP dark
  // cycles; play stops after last_round, at index 31, or before an empty
  // entry. One done cycle follows, then the block idles holding step.
  task automatic build_trace(input logic [31:0][2:0] s, input int lr);
    int   last;
    obs_t o;
    exp_q.delete();
    last = 0;
    for (int i = 0; i <= lr && i < 32; i++) begin
      if (s[i][2]) break;
      for (int c = 0; c < ON; c++) begin
        o = '{leds: 4'b0001 << s[i][1:0], busy: 1'b1, done: 1'b0, step: 5'(i)};
        exp_q.push_back(o);
      end
      for (int c = 0; c < GAP; c++) begin
        o = '{leds: 4'b0000, busy: 1'b1, done: 1'b0, step: 5'(i)};
        exp_q.push_back(o);
      end
      last = i;
    end
    o = '{leds: 4'b0000, busy: 1'b0, done: 1'b1, step: 5'(last)};
    exp_q.push_back(o);
    o.done = 1'b0;
    exp_q.push_back(o);
    exp_q.push_back(o);
  endtask

  // Pulses start, then compares every following cycle against the model.
  // A second start is asserted during trace cycle poke_at (-1 for none).
  task automatic play(input string tag, input int poke_at);
    build_trace(segment, int'(last_round));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      check(tag, exp_q[i]);
      start = (i == poke_at);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic fill_empty();
    for (int i = 0; i < 32; i++) segment[i] = 3'b100;
  endtask

  task automatic fill_random(input int empty_one_in);
    for (int i = 0; i < 32; i++) begin
      segment[i][2]   = ($urandom_range(0, empty_one_in - 1) == 0);
      segment[i][1:0] = 2'($urandom);
    end
    segment[0][2] = 1'b0;
  endtask

  initial begin
    obs_t zero;
    zero       = '0;
    reset      = 1'b1;
    start      = 1'b0;
    last_round = 5'd0;
    fill_empty();
    #12;
    check("reset_state", zero);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("idle_after_reset", zero);

    // 1: three entries 3,0,2 with last_round=2.
    fill_empty();
    segment[0] = 3'd3;
    segment[1] = 3'd0;
    segment[2] = 3'd2;
    last_round = 5'd2;
    play("basic3", -1);

    // 2: first entry empty; a start landing on the done cycle is ignored.
    fill_empty();
    last_round = 5'd5;
    play("empty_first", 0);

    // 3: entries 0..3 valid, entry 4 empty, last_round beyond them.
    fill_empty();
    for (int i = 0; i < 4; i++) segment[i] = 3'(i);
    last_round = 5'd10;
    play("stop_at_empty", -1);

    // 4: second start during step 1 of a three-step playback.
    fill_empty();
    segment[0] = 3'd1;
    segment[1] = 3'd2;
    segment[2] = 3'd3;
    last_round = 5'd2;
    play("restart_ignored", ON + GAP + 1);

    // 5: asynchronous reset between clock edges while in SHOW.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", zero);
    @(negedge clk);
    reset = 1'b0;
    tick();
    play("after_reset", -1);

    // 6: all 32 entries valid, last_round=31; step must end at 31.
    fill_random(1_000_000);
    for (int i = 0; i < 32; i++) segment[i][2] = 1'b0;
    last_round = 5'd31;
    play("full32", -1);

    // Randomised runs, with a start landing on the done cycle in each.
    for (int r = 0; r < 6; r++) begin
      fill_random(8);
      last_round = 5'($urandom_range(0, 31));
      build_trace(segment, int'(last_round));
      play("random", exp_q.size() - 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
